reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter INDEX_BIT_WIDTH, default 4, sets the register index width.
REQ-002 Parameter DATA_BIT_WIDTH, default 32, sets the register data width.
REQ-003 Parameter N_REGS, default 1<<INDEX_BIT_WIDTH, sets the number of registers (indices 0..N_REGS-1).
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 wrtEn  input  1  write strobe.
REQ-009 wrtIndex  input  INDEX_BIT_WIDTH  write destination.
REQ-010 dataIn  input  DATA_BIT_WIDTH  write data.
REQ-011 rsvEn  input  1  reserve strobe; marks the destination of an issued instruction as busy.
REQ-012 rsvIndex  input  INDEX_BIT_WIDTH  register to reserve.
REQ-013 flush  input  1  clears all reservations.
REQ-014 rdIndex1, rdIndex2  input  INDEX_BIT_WIDTH each  read addresses.
REQ-015 dataOut1, dataOut2  output  DATA_BIT_WIDTH each  read data.
REQ-016 rdy1, rdy2  output  1 each  operand valid (not pending).
REQ-017 busyCount  output  INDEX_BIT_WIDTH+1  number of busy registers.

Function
REQ-018 Reads SHALL be combinational with zero latency: dataOutN = data[rdIndexN].
REQ-019 Write bypass: when wrtEn=1 and wrtIndex==rdIndexN, dataOutN SHALL equal dataIn in the same cycle.
REQ-020 rdyN SHALL be 1 when busy[rdIndexN]=0, or when wrtEn=1 and wrtIndex==rdIndexN; otherwise 0.
REQ-021 On a clk edge with wrtEn=1: data[wrtIndex] <= dataIn and busy[wrtIndex] <= 0, unless REQ-022 applies.
REQ-022 On a clk edge with rsvEn=1 and flush=0: busy[rsvIndex] <= 1. Reserve beats write clear on the same index, so the newer producer wins.
REQ-023 Reserving an already-busy register (WAW) SHALL leave it busy, with no busyCount change.
REQ-024 Writing a non-busy register SHALL update its data and leave busy at 0.
REQ-025 On a clk edge with flush=1: all busy bits <= 0 and busyCount <= 0; rsvEn is ignored; a concurrent write SHALL still update data.
REQ-026 When ZERO_REG=1: writes and reserves to index 0 are ignored; dataOutN=0 and rdyN=1 when rdIndexN=0, including no bypass.
REQ-027 busyCount SHALL equal the population count of the busy vector after every edge (range 0..N_REGS, no wrap).
REQ-028 Indices >= N_REGS SHALL be ignored for writes and reserves; reads at such indices return 0 with rdy=1.

Reset
REQ-029 While rst_n=0, independent of clk: all data <= 0, all busy <= 0, busyCount <= 0.
REQ-030 Reset asserted mid-operation SHALL discard pending reservations and writes in that cycle.
REQ-031 Following from REQ-029, after reset every dataOutN=0 and rdyN=1.

Structure
REQ-032 Package reg_file_pkg SHALL hold the default widths and the ZERO_REG default.
REQ-033 Sub-module reg_scoreboard SHALL hold the busy vector and busyCount (inputs wrtEn, wrtIndex, rsvEn, rsvIndex, flush); the data array stays in reg_file_sb.

Verification
REQ-034 Reset, then read r3 -> dataOut=0, rdy=1, busyCount=0.
REQ-035 Reserve r5; next cycle read r5 -> rdy=0, busyCount=1; write r5=0xDEADBEEF -> same cycle dataOut=0xDEADBEEF, rdy=1; following cycle busyCount=0.
REQ-036 Same cycle: write r7=0x11 and reserve r7 -> next cycle data[r7]=0x11, rdy7=0, busyCount=1.
REQ-037 Reserve r1, r2, r3, then flush with rsvEn for r4 -> busyCount=0, r4 not busy.
REQ-038 ZERO_REG=1: write r0=0xFFFFFFFF and reserve r0 -> read r0 gives 0, rdy=1, busyCount unchanged.
REQ-039 Reserve r9 and pulse rst_n low mid-cycle -> immediately busyCount=0 and data[r9]=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and index helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEFAULT_INDEX_BIT_WIDTH = 4;
  localparam int DEFAULT_DATA_BIT_WIDTH  = 32;
  localparam int DEFAULT_ZERO_REG        = 1;

  // True when register idx physically exists and may be written or reserved.
  // Out-of-range indices and a hardwired r0 are never writable.
  function automatic bit isWritable(int idx, int nRegs, int zeroReg);
    return (idx < nRegs) && !((zeroReg != 0) && (idx == 0));
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks which registers have an outstanding producer.
// A reservation marks a register busy; the producer's write clears it.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int INDEX_BIT_WIDTH = DEFAULT_INDEX_BIT_WIDTH,
  parameter int N_REGS          = 1 << INDEX_BIT_WIDTH,
  parameter int ZERO_REG        = DEFAULT_ZERO_REG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wrtEn,
  input  logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
  input  logic                       rsvEn,
  input  logic [INDEX_BIT_WIDTH-1:0] rsvIndex,
  input  logic                       flush,
  output logic [N_REGS-1:0]          busy,
  output logic [INDEX_BIT_WIDTH:0]   busyCount
);

  logic [N_REGS-1:0] busyNext;

  // Next busy vector: flush clears everything, otherwise write clears and
  // reserve sets, with the reserve applied last so the newer producer wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    busyNext = busy;
    if (flush) begin
      busyNext = '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (isWritable(i, N_REGS, ZERO_REG)) begin
          if (wrtEn && (wrtIndex == INDEX_BIT_WIDTH'(i))) busyNext[i] = 1'b0;
          if (rsvEn && (rsvIndex == INDEX_BIT_WIDTH'(i))) busyNext[i] = 1'b1;
        end
      end
    end
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) busy <= '0;
    else        busy <= busyNext;
  end

  // Population count of the busy vector; tracks the register exactly, so it
  // can never drift or wrap.
  always_comb begin
    busyCount = '0;
    for (int i = 0; i < N_REGS; i++) begin
      busyCount = busyCount + (INDEX_BIT_WIDTH + 1)'(busy[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with write bypass and a busy-bit
// scoreboard reporting operand readiness for each read port.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int INDEX_BIT_WIDTH = DEFAULT_INDEX_BIT_WIDTH,
  parameter int DATA_BIT_WIDTH  = DEFAULT_DATA_BIT_WIDTH,
  parameter int N_REGS          = 1 << INDEX_BIT_WIDTH,
  parameter int ZERO_REG        = DEFAULT_ZERO_REG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wrtEn,
  input  logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
  input  logic [DATA_BIT_WIDTH-1:0]  dataIn,
  input  logic                       rsvEn,
  input  logic [INDEX_BIT_WIDTH-1:0] rsvIndex,
  input  logic                       flush,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
  input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
  output logic [DATA_BIT_WIDTH-1:0]  dataOut1,
  output logic [DATA_BIT_WIDTH-1:0]  dataOut2,
  output logic                       rdy1,
  output logic                       rdy2,
  output logic [INDEX_BIT_WIDTH:0]   busyCount
);

  logic [DATA_BIT_WIDTH-1:0]  data   [N_REGS];
  logic [N_REGS-1:0]          busy;
  logic [INDEX_BIT_WIDTH-1:0] rdIdx  [2];
  logic [DATA_BIT_WIDTH-1:0]  rdData [2];
  logic                       rdRdy  [2];

  reg_scoreboard #(
    .INDEX_BIT_WIDTH(INDEX_BIT_WIDTH),
    .N_REGS         (N_REGS),
    .ZERO_REG       (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrtEn    (wrtEn),
    .wrtIndex (wrtIndex),
    .rsvEn    (rsvEn),
    .rsvIndex (rsvIndex),
    .flush    (flush),
    .busy     (busy),
    .busyCount(busyCount)
  );

  // Data array write; flush does not block writes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is deliberately reset, because reads after reset must
    // return zero; this keeps it in flops rather than a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (isWritable(i, N_REGS, ZERO_REG) && wrtEn &&
            (wrtIndex == INDEX_BIT_WIDTH'(i))) begin
          data[i] <= dataIn;
        end
      end
    end
  end

  assign rdIdx[0] = rdIndex1;
  assign rdIdx[1] = rdIndex2;

  // Zero-latency read ports with same-cycle write bypass; r0 (when hardwired)
  // and nonexistent registers read as zero and always ready.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = '0;
      rdRdy[p]  = 1'b1;
      for (int i = 0; i < N_REGS; i++) begin
        if (isWritable(i, N_REGS, ZERO_REG) && (rdIdx[p] == INDEX_BIT_WIDTH'(i))) begin
          if (wrtEn && (wrtIndex == rdIdx[p])) begin
            rdData[p] = dataIn;
            rdRdy[p]  = 1'b1;
          end else begin
            rdData[p] = data[i];
            rdRdy[p]  = ~busy[i];
          end
        end
      end
    end
  end

  assign dataOut1 = rdData[0];
  assign dataOut2 = rdData[1];
  assign rdy1     = rdRdy[0];
  assign rdy2     = rdRdy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic, checked by a
// scoreboard fed from an architectural model of the register file.
module tb_reg_file_sb;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int NR = 12;   // fewer than 2**IW so indices 12..15 are out of range

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wrtEn;
  logic [IW-1:0] wrtIndex;
  logic [DW-1:0] dataIn;
  logic          rsvEn;
  logic [IW-1:0] rsvIndex;
  logic          flush;
  logic [IW-1:0] rdIndex1;
  logic [IW-1:0] rdIndex2;
  logic [DW-1:0] dataOut1;
  logic [DW-1:0] dataOut2;
  logic          rdy1;
  logic          rdy2;
  logic [IW:0]   busyCount;

  reg_file_sb #(
    .INDEX_BIT_WIDTH(IW),
    .DATA_BIT_WIDTH (DW),
    .N_REGS         (NR),
    .ZERO_REG       (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrtEn    (wrtEn),
    .wrtIndex (wrtIndex),
    .dataIn   (dataIn),
    .rsvEn    (rsvEn),
    .rsvIndex (rsvIndex),
    .flush    (flush),
    .rdIndex1 (rdIndex1),
    .rdIndex2 (rdIndex2),
    .dataOut1 (dataOut1),
    .dataOut2 (dataOut2),
    .rdy1     (rdy1),
    .rdy2     (rdy2),
    .busyCount(busyCount)
  );

  always #5 clk = ~clk;

  // Architectural model: one value and one pending flag per register.
  logic [DW-1:0] mData [16];
  logic [15:0]   mBusy;

  typedef struct {
    logic [DW-1:0] d1;
    logic          r1;
    logic [DW-1:0] d2;
    logic          r2;
    logic [IW:0]   cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exists(int idx);
    return idx >= 1 && idx < NR;
  endfunction

  // What a read at idx returns given the model state and the current inputs.
  task automatic modelRead(input int idx, output logic [DW-1:0] d, output logic r);
    if (!exists(idx)) begin
      d = '0; r = 1'b1;
    end else if (wrtEn && int'(wrtIndex) == idx) begin
      d = dataIn; r = 1'b1;
    end else begin
      d = mData[idx]; r = !mBusy[idx];
    end
  endtask

  // Effect of one clock edge on the model.
  task automatic modelEdge();
    if (wrtEn && exists(int'(wrtIndex))) begin
      mData[wrtIndex] = dataIn;
      mBusy[wrtIndex] = 1'b0;
    end
    if (flush) mBusy = '0;
    else if (rsvEn && exists(int'(rsvIndex))) mBusy[rsvIndex] = 1'b1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mData[i] = '0;
    mBusy = '0;
  endtask

  // Apply a set of inputs and queue the response the model predicts for them.
  task automatic drive(bit we, int wi, logic [DW-1:0] di, bit re, int ri, bit fl,
                       int r1, int r2);
    exp_t e;
    wrtEn = we; wrtIndex = IW'(wi); dataIn = di;
    rsvEn = re; rsvIndex = IW'(ri); flush = fl;
    rdIndex1 = IW'(r1); rdIndex2 = IW'(r2);
    modelRead(r1, e.d1, e.r1);
    modelRead(r2, e.d2, e.r2);
    e.cnt = (IW + 1)'($countones(mBusy));
    expQ.push_back(e);
  endtask

  task automatic idle(int r1, int r2);
    drive(0, 0, '0, 0, 0, 0, r1, r2);
  endtask

  // Advance one clock edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) modelEdge();
    #1;
  endtask

  // Monitor: outputs are combinational, so every queued prediction is
  // compared on the falling edge that follows its stimulus.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      check("sb_dataOut1", dataOut1, monExp.d1);
      check("sb_rdy1", DW'(rdy1), DW'(monExp.r1));
      check("sb_dataOut2", dataOut2, monExp.d2);
      check("sb_rdy2", DW'(rdy2), DW'(monExp.r2));
      check("sb_busyCount", DW'(busyCount), DW'(monExp.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wi;
    rst_n = 1'b0;
    wrtEn = 0; wrtIndex = '0; dataIn = '0; rsvEn = 0; rsvIndex = '0;
    flush = 0; rdIndex1 = '0; rdIndex2 = '0;
    modelReset();
    tick(); tick();
    rst_n = 1'b1;

    // Fresh after reset: r3 reads zero and ready, nothing busy.
    idle(3, 3);
    #2;
    check("reset_dataOut", dataOut1, 32'h0);
    check("reset_rdy", DW'(rdy1), 32'h1);
    check("reset_busyCount", DW'(busyCount), 32'h0);
    tick();

    // Reserve r5, then satisfy it with a bypassed write.
    drive(0, 0, '0, 1, 5, 0, 5, 0);
    tick();
    idle(5, 0);
    #2;
    check("rsv5_rdy", DW'(rdy1), 32'h0);
    check("rsv5_busyCount", DW'(busyCount), 32'h1);
    tick();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    #2;
    check("bypass5_data", dataOut1, 32'hDEADBEEF);
    check("bypass5_rdy", DW'(rdy1), 32'h1);
    tick();
    idle(5, 0);
    #2;
    check("wr5_busyCount", DW'(busyCount), 32'h0);
    check("wr5_data", dataOut1, 32'hDEADBEEF);
    tick();

    // Write and reserve r7 together: data lands, reservation survives.
    drive(1, 7, 32'h11, 1, 7, 0, 7, 0);
    tick();
    idle(7, 0);
    #2;
    check("wr_rsv7_data", dataOut1, 32'h11);
    check("wr_rsv7_rdy", DW'(rdy1), 32'h0);
    check("wr_rsv7_busyCount", DW'(busyCount), 32'h1);
    tick();

    // Reserve r1..r3, then flush while reserving r4.
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, '0, 1, i, 0, i, 0);
      tick();
    end
    drive(0, 0, '0, 1, 4, 1, 4, 0);
    tick();
    idle(4, 1);
    #2;
    check("flush_busyCount", DW'(busyCount), 32'h0);
    check("flush_rdy4", DW'(rdy1), 32'h1);
    tick();

    // Hardwired r0: writes and reserves ignored, no bypass.
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    #2;
    check("r0_bypass_data", dataOut1, 32'h0);
    check("r0_bypass_rdy", DW'(rdy1), 32'h1);
    tick();
    idle(0, 0);
    #2;
    check("r0_data", dataOut1, 32'h0);
    check("r0_busyCount", DW'(busyCount), 32'h0);
    tick();

    // Nonexistent register 13: ignored, reads zero and ready.
    drive(1, 13, 32'hCAFE0013, 1, 13, 0, 13, 0);
    #2;
    check("oor_bypass_data", dataOut1, 32'h0);
    tick();
    idle(13, 0);
    #2;
    check("oor_data", dataOut1, 32'h0);
    check("oor_busyCount", DW'(busyCount), 32'h0);
    tick();

    // Asynchronous reset mid-cycle with r9 written and reserved.
    drive(1, 9, 32'hA5A5A5A5, 1, 9, 0, 9, 0);
    tick();
    wrtEn = 0; rsvEn = 1; rsvIndex = IW'(9); rdIndex1 = IW'(9);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    check("async_rst_busyCount", DW'(busyCount), 32'h0);
    check("async_rst_data9", dataOut1, 32'h0);
    check("async_rst_rdy9", DW'(rdy1), 32'h1);
    tick();
    #2;
    check("held_rst_busyCount", DW'(busyCount), 32'h0);
    rsvEn = 0;
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wi = $urandom_range(0, 15);
      drive($urandom_range(0, 1), wi, $urandom,
            ($urandom_range(0, 9) < 4), $urandom_range(0, 15),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0) ? wi : $urandom_range(0, 15),
            ($urandom_range(0, 3) == 0) ? wi : $urandom_range(0, 15));
      tick();
    end

    idle(0, 0);
    tick();
    tick();
    check("queue_drained", DW'(expQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
